// File: rtl/flag_pkg.sv
// Shared opcode, flag-index and condition-code definitions for the flag unit,
// plus the per-opcode write mask and per-condition read set lookups.
package flag_pkg;

   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b0001;
   localparam logic [3:0] OP_XOR    = 4'b0010;
   localparam logic [3:0] OP_RED    = 4'b0011;
   localparam logic [3:0] OP_SLL    = 4'b0100;
   localparam logic [3:0] OP_SRA    = 4'b0101;
   localparam logic [3:0] OP_ROR    = 4'b0110;
   localparam logic [3:0] OP_PADDSB = 4'b0111;

   localparam logic [2:0] CC_NE  = 3'b000;
   localparam logic [2:0] CC_EQ  = 3'b001;
   localparam logic [2:0] CC_GT  = 3'b010;
   localparam logic [2:0] CC_LT  = 3'b011;
   localparam logic [2:0] CC_GE  = 3'b100;
   localparam logic [2:0] CC_LE  = 3'b101;
   localparam logic [2:0] CC_OVF = 3'b110;
   localparam logic [2:0] CC_UNC = 3'b111;

   function automatic logic [2:0] write_mask(input logic [3:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         OP_ADD, OP_SUB: begin
            m[FLAG_Z] = 1'b1;
            m[FLAG_V] = 1'b1;
            m[FLAG_N] = 1'b1;
         end
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
         OP_RED, OP_PADDSB:              m = 3'b000;
         default:                        m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] read_set(input logic [2:0] cond);
      logic [2:0] r;
      r = 3'b000;
      case (cond)
         CC_NE, CC_EQ:        r[FLAG_Z] = 1'b1;
         CC_GT, CC_GE, CC_LE: begin
            r[FLAG_Z] = 1'b1;
            r[FLAG_N] = 1'b1;
         end
         CC_LT:               r[FLAG_N] = 1'b1;
         CC_OVF:              r[FLAG_V] = 1'b1;
         CC_UNC:              r = 3'b000;
         default:             r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/flag_calc.sv
// Combinational candidate-flag generator for the EX-stage ALU op.
// Z/N come from the (possibly saturated) result; V from the raw, unsaturated sum.
module flag_calc
   import flag_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [3:0]    opcode,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] result,
   output logic [2:0]    cand,
   output logic [2:0]    wr_mask
);

   logic [DW-1:0] raw_add;
   logic [DW-1:0] raw_sub;
   logic          v_add;
   logic          v_sub;

   always_comb begin
      raw_add = a + b;
      raw_sub = a - b;
      v_add   = (a[DW-1] == b[DW-1]) && (raw_add[DW-1] != a[DW-1]);
      v_sub   = (a[DW-1] != b[DW-1]) && (raw_sub[DW-1] != a[DW-1]);

      cand         = 3'b000;
      cand[FLAG_Z] = (result == '0);
      cand[FLAG_N] = result[DW-1];
      cand[FLAG_V] = (opcode == OP_SUB) ? v_sub : v_add;

      wr_mask = write_mask(opcode);
   end

endmodule

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register with EX-retirement commit, combinational
// branch flag-hazard detection, and a saturating hazard-cycle counter.
module flag_unit
   import flag_pkg::*;
#(
   parameter int DW    = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [3:0]       ex_opcode,
   input  logic [DW-1:0]    ex_a,
   input  logic [DW-1:0]    ex_b,
   input  logic [DW-1:0]    ex_result,
   input  logic             ex_stall,
   input  logic             ex_flush,
   input  logic             id_is_branch,
   input  logic [2:0]       id_cond,
   output logic [2:0]       flags,
   output logic             flag_hazard,
   output logic [CNT_W-1:0] hazard_cnt
);

   typedef enum logic {HZ_CLEAR = 1'b0, HZ_WAIT = 1'b1} hz_state_e;

   logic [2:0]       cand;
   logic [2:0]       wr_mask;
   logic             commit;
   logic             count_en;
   logic [2:0]       flags_d,  flags_q;
   logic [CNT_W-1:0] cnt_d,    cnt_q;
   hz_state_e        state_d,  state_q;

   flag_calc #(.DW(DW)) u_calc (
      .opcode  (ex_opcode),
      .a       (ex_a),
      .b       (ex_b),
      .result  (ex_result),
      .cand    (cand),
      .wr_mask (wr_mask)
   );

   always_comb begin
      commit      = ex_valid & ~ex_stall & ~ex_flush;
      // Stall does not mask the hazard: a held writer still owes its flags.
      flag_hazard = id_is_branch & ex_valid & ~ex_flush & (|(read_set(id_cond) & wr_mask));
      flags_d     = commit ? ((flags_q & ~wr_mask) | (cand & wr_mask)) : flags_q;
   end

   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      case (state_q)
         HZ_CLEAR: begin
            if (flag_hazard) begin
               state_d  = HZ_WAIT;
               count_en = 1'b1;
            end
         end
         HZ_WAIT: begin
            count_en = flag_hazard;
            if (commit || ex_flush) state_d = HZ_CLEAR;
         end
         default: state_d = HZ_CLEAR;
      endcase
      cnt_d = (count_en && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= 3'b000;
         cnt_q   <= '0;
         state_q <= HZ_CLEAR;
      end else begin
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign flags      = flags_q;
   assign hazard_cnt = cnt_q;

endmodule
